bus_cycle_sequencer: RTL and testbench

Generates the T-state sequence for every Z80 machine cycle (opcode fetch, memory read/write, I/O read/write, interrupt acknowledge), including automatic and WAIT-inserted wait states and the BUSRQ/BUSACK bus hand-over. It sits between the instruction decode/execute control, which requests machine cycles, and the pin control logic, which consumes the one-hot T-states and function strobes produced here. The block is the only source of T1..T4 and Tw timing in the CPU.

---
 rtl/bus_cycle_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// Z80 machine-cycle T-state sequencer.
// Produces one-hot T1/T2/Tw/T3/T4 timing, latched function strobes, auto and
// WAIT-inserted wait states, and the BUSRQ/BUSACK bus hand-over.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no machine cycle in progress, bus owned
// ST_T1     | first T-state, function just latched
// ST_T2     | second T-state, auto-wait counter loads here
// ST_TWA    | automatic wait state (I/O, interrupt acknowledge)
// ST_TWI    | wait state inserted by the WAIT pin
// ST_T3     | third T-state, last one for mem read/write and I/O
// ST_T4     | fourth T-state, last one for fetch and interrupt acknowledge
// ST_BUSACK | bus released to an external master
module bus_cycle_sequencer #(
    parameter int unsigned IO_AUTO_WAIT   = 1,
    parameter int unsigned INTA_AUTO_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cyc_req,
    input  logic [2:0] cyc_func,
    input  logic       mwait,
    input  logic       busrq,
    output logic       cyc_ack,
    output logic       T1,
    output logic       T2,
    output logic       Tw,
    output logic       T3,
    output logic       T4,
    output logic       tw_auto,
    output logic       fFetch,
    output logic       fMRead,
    output logic       fMWrite,
    output logic       fIORead,
    output logic       fIOWrite,
    output logic       in_intr,
    output logic       setM1,
    output logic       busack,
    output logic [7:0] wait_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TWA,
        ST_TWI,
        ST_T3,
        ST_T4,
        ST_BUSACK
    } state_t;

    localparam logic [1:0] IO_AW   = 2'(IO_AUTO_WAIT);
    localparam logic [1:0] INTA_AW = 2'(INTA_AUTO_WAIT);

    state_t     state_q, state_d;
    logic [2:0] func_q;
    logic [1:0] aw_cnt_q;
    logic       ack_c;
    logic       wait_inc;

    logic       is_fetch, is_mread, is_mwrite, is_ioread, is_iowrite, is_inta;
    logic       four_t, auto_wait;
    logic [1:0] aw_load;
    logic       req_ok, is_last, boundary, active;

    assign is_fetch   = (func_q == 3'd0);
    assign is_mread   = (func_q == 3'd1);
    assign is_mwrite  = (func_q == 3'd2);
    assign is_ioread  = (func_q == 3'd3);
    assign is_iowrite = (func_q == 3'd4);
    assign is_inta    = (func_q == 3'd5);

    assign four_t    = is_fetch | is_inta;
    assign auto_wait = is_ioread | is_iowrite | is_inta;
    assign aw_load   = is_inta ? INTA_AW : ((is_ioread | is_iowrite) ? IO_AW : 2'd0);

    // Functions 6/7 are illegal and look exactly like no request at all.
    assign req_ok   = cyc_req & (cyc_func <= 3'd5);
    assign is_last  = (state_q == ST_T4) | ((state_q == ST_T3) & ~four_t);
    assign boundary = (state_q == ST_IDLE) | is_last;
    assign active   = (state_q != ST_IDLE) & (state_q != ST_BUSACK);

    // Next-state selection; boundaries arbitrate busrq over a new cycle request.
    always_comb begin
        state_d  = state_q;
        ack_c    = 1'b0;
        wait_inc = 1'b0;
        if (boundary) begin
            if (busrq) begin
                state_d = ST_BUSACK;
            end else if (req_ok) begin
                state_d = ST_T1;
                ack_c   = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_T1: state_d = ST_T2;
                ST_T2: begin
                    if (auto_wait && (aw_load != 2'd0)) begin
                        state_d = ST_TWA;
                    end else if (mwait) begin
                        state_d  = ST_TWI;
                        wait_inc = 1'b1;
                    end else begin
                        state_d = ST_T3;
                    end
                end
                ST_TWA: begin
                    if (aw_cnt_q > 2'd1) begin
                        state_d = ST_TWA;
                    end else if (mwait) begin
                        state_d  = ST_TWI;
                        wait_inc = 1'b1;
                    end else begin
                        state_d = ST_T3;
                    end
                end
                ST_TWI: begin
                    if (mwait) begin
                        state_d  = ST_TWI;
                        wait_inc = 1'b1;
                    end else begin
                        state_d = ST_T3;
                    end
                end
                ST_T3:     state_d = ST_T4;
                ST_BUSACK: state_d = busrq ? ST_BUSACK : ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Function latch, captured on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      func_q <= 3'd0;
        else if (ack_c) func_q <= cyc_func;
    end

    // Auto-wait counter: loaded in T2, counts down once per TWA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       aw_cnt_q <= 2'd0;
        else if (state_q == ST_T2)                       aw_cnt_q <= aw_load;
        else if ((state_q == ST_TWA) && (aw_cnt_q != 0)) aw_cnt_q <= aw_cnt_q - 2'd1;
    end

    // WAIT-inserted state count, cleared when a new cycle starts, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            wait_cnt <= 8'd0;
        else if (ack_c)                       wait_cnt <= 8'd0;
        else if (wait_inc && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end

    // Decoded outputs; cyc_ack is masked so reset never lets a pulse through.
    always_comb begin
        cyc_ack  = ack_c & ~reset;
        T1       = (state_q == ST_T1);
        T2       = (state_q == ST_T2);
        Tw       = (state_q == ST_TWA) | (state_q == ST_TWI);
        T3       = (state_q == ST_T3);
        T4       = (state_q == ST_T4);
        tw_auto  = (state_q == ST_TWA);
        fFetch   = active & four_t;
        fMRead   = active & is_mread;
        fMWrite  = active & is_mwrite;
        fIORead  = active & is_ioread;
        fIOWrite = active & is_iowrite;
        in_intr  = active & is_inta;
        setM1    = is_last;
        busack   = (state_q == ST_BUSACK);
    end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Scoreboard bench for bus_cycle_sequencer with directed, hand-computed vectors.
module tb_bus_cycle_sequencer;

    typedef struct packed {
        logic       ack;
        logic [4:0] t;      // T1,T2,Tw,T3,T4
        logic       twa;
        logic [4:0] f;      // fetch, mread, mwrite, ioread, iowrite
        logic       intr;
        logic       m1;
        logic       ba;
        logic [7:0] wc;
    } obs_t;

    localparam logic [4:0] S_NO = 5'b00000, S_T1 = 5'b10000, S_T2 = 5'b01000,
                           S_TW = 5'b00100, S_T3 = 5'b00010, S_T4 = 5'b00001;
    localparam logic [4:0] F_NO = 5'b00000, F_FE = 5'b10000, F_MR = 5'b01000,
                           F_MW = 5'b00100, F_IR = 5'b00010, F_IW = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cyc_req = 1'b0;
    logic [2:0] cyc_func = 3'd0;
    logic       mwait = 1'b0;
    logic       busrq = 1'b0;
    logic       cyc_ack, T1, T2, Tw, T3, T4, tw_auto;
    logic       fFetch, fMRead, fMWrite, fIORead, fIOWrite, in_intr, setM1, busack;
    logic [7:0] wait_cnt;

    int errors = 0;
    int checks = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    bus_cycle_sequencer #(.IO_AUTO_WAIT(1), .INTA_AUTO_WAIT(2)) dut (
        .clk(clk), .reset(reset), .cyc_req(cyc_req), .cyc_func(cyc_func),
        .mwait(mwait), .busrq(busrq), .cyc_ack(cyc_ack),
        .T1(T1), .T2(T2), .Tw(Tw), .T3(T3), .T4(T4), .tw_auto(tw_auto),
        .fFetch(fFetch), .fMRead(fMRead), .fMWrite(fMWrite),
        .fIORead(fIORead), .fIOWrite(fIOWrite), .in_intr(in_intr),
        .setM1(setM1), .busack(busack), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic ack, logic [4:0] t, logic twa, logic [4:0] f,
                                logic intr, logic m1, logic ba, logic [7:0] wc);
        obs_t o;
        o.ack = ack; o.t = t; o.twa = twa; o.f = f;
        o.intr = intr; o.m1 = m1; o.ba = ba; o.wc = wc;
        return o;
    endfunction

    // One clock of stimulus: drive inputs just after the edge, queue the
    // response expected for the rest of this clock.
    task automatic step(input string tag, input logic rq, input logic [2:0] fn,
                        input logic w, input logic br, input logic rst, input obs_t e);
        @(posedge clk);
        #1;
        cyc_req  = rq;
        cyc_func = fn;
        mwait    = w;
        busrq    = br;
        reset    = rst;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: compares the DUT view on the falling edge against the queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e, a;
            string tg;
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            a  = {cyc_ack, T1, T2, Tw, T3, T4, tw_auto,
                  fFetch, fMRead, fMWrite, fIORead, fIOWrite,
                  in_intr, setM1, busack, wait_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got ack=%b t=%b twa=%b f=%b intr=%b m1=%b ba=%b wc=%0d, expected ack=%b t=%b twa=%b f=%b intr=%b m1=%b ba=%b wc=%0d",
                         tg, a.ack, a.t, a.twa, a.f, a.intr, a.m1, a.ba, a.wc,
                         e.ack, e.t, e.twa, e.f, e.intr, e.m1, e.ba, e.wc);
            end
        end
    end

    initial begin
        obs_t z;
        z = mk(0, S_NO, 0, F_NO, 0, 0, 0, 8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fetch, held request gives back-to-back fetch
        step("fe_idle", 1, 0, 0, 0, 0, mk(1, S_NO, 0, F_NO, 0, 0, 0, 0));
        step("fe_t1",   1, 0, 0, 0, 0, mk(0, S_T1, 0, F_FE, 0, 0, 0, 0));
        step("fe_t2",   1, 0, 0, 0, 0, mk(0, S_T2, 0, F_FE, 0, 0, 0, 0));
        step("fe_t3",   1, 0, 0, 0, 0, mk(0, S_T3, 0, F_FE, 0, 0, 0, 0));
        step("fe_t4",   1, 0, 0, 0, 0, mk(1, S_T4, 0, F_FE, 0, 1, 0, 0));
        step("fe2_t1",  0, 0, 0, 0, 0, mk(0, S_T1, 0, F_FE, 0, 0, 0, 0));
        step("fe2_t2",  0, 0, 0, 0, 0, mk(0, S_T2, 0, F_FE, 0, 0, 0, 0));
        step("fe2_t3",  0, 0, 0, 0, 0, mk(0, S_T3, 0, F_FE, 0, 0, 0, 0));
        step("fe2_t4",  0, 0, 0, 0, 0, mk(0, S_T4, 0, F_FE, 0, 1, 0, 0));

        // I/O read, one auto wait, WAIT high for two samples
        step("io_idle", 1, 3, 0, 0, 0, mk(1, S_NO, 0, F_NO, 0, 0, 0, 0));
        step("io_t1",   0, 3, 0, 0, 0, mk(0, S_T1, 0, F_IR, 0, 0, 0, 0));
        step("io_t2",   0, 3, 1, 0, 0, mk(0, S_T2, 0, F_IR, 0, 0, 0, 0));
        step("io_twa",  0, 3, 1, 0, 0, mk(0, S_TW, 1, F_IR, 0, 0, 0, 0));
        step("io_twi1", 0, 3, 1, 0, 0, mk(0, S_TW, 0, F_IR, 0, 0, 0, 1));
        step("io_twi2", 0, 3, 0, 0, 0, mk(0, S_TW, 0, F_IR, 0, 0, 0, 2));
        step("io_t3",   0, 3, 0, 0, 0, mk(0, S_T3, 0, F_IR, 0, 1, 0, 2));

        // Interrupt acknowledge, two auto waits
        step("ia_idle", 1, 5, 0, 0, 0, mk(1, S_NO, 0, F_NO, 0, 0, 0, 2));
        step("ia_t1",   0, 5, 0, 0, 0, mk(0, S_T1, 0, F_FE, 1, 0, 0, 0));
        step("ia_t2",   0, 5, 0, 0, 0, mk(0, S_T2, 0, F_FE, 1, 0, 0, 0));
        step("ia_twa1", 0, 5, 1, 0, 0, mk(0, S_TW, 1, F_FE, 1, 0, 0, 0));
        step("ia_twa2", 0, 5, 0, 0, 0, mk(0, S_TW, 1, F_FE, 1, 0, 0, 0));
        step("ia_t3",   0, 5, 0, 0, 0, mk(0, S_T3, 0, F_FE, 1, 0, 0, 0));
        step("ia_t4",   0, 5, 0, 0, 0, mk(0, S_T4, 0, F_FE, 1, 1, 0, 0));

        // Mem read with busrq raised in T2 while the next request is pending
        step("mr_idle", 1, 1, 0, 0, 0, mk(1, S_NO, 0, F_NO, 0, 0, 0, 0));
        step("mr_t1",   0, 1, 0, 0, 0, mk(0, S_T1, 0, F_MR, 0, 0, 0, 0));
        step("mr_t2",   1, 2, 0, 1, 0, mk(0, S_T2, 0, F_MR, 0, 0, 0, 0));
        step("mr_t3",   1, 2, 0, 1, 0, mk(0, S_T3, 0, F_MR, 0, 1, 0, 0));
        for (int i = 0; i < 10; i++)
            step("busack_held", 1, 2, 0, 1, 0, mk(0, S_NO, 0, F_NO, 0, 0, 1, 0));
        step("busack_rel", 1, 2, 0, 0, 0, mk(0, S_NO, 0, F_NO, 0, 0, 1, 0));

        // Mem write into WAIT states, then reset in the middle of TWI
        step("mw_idle", 1, 2, 0, 0, 0, mk(1, S_NO, 0, F_NO, 0, 0, 0, 0));
        step("mw_t1",   0, 2, 0, 0, 0, mk(0, S_T1, 0, F_MW, 0, 0, 0, 0));
        step("mw_t2",   0, 2, 1, 0, 0, mk(0, S_T2, 0, F_MW, 0, 0, 0, 0));
        step("mw_twi",  0, 2, 1, 0, 0, mk(0, S_TW, 0, F_MW, 0, 0, 0, 1));
        step("rst_async", 0, 2, 1, 0, 0, z);
        #2 reset = 1'b1;
        step("rst_hold", 1, 1, 0, 0, 1, z);
        step("rst_hold", 1, 1, 0, 0, 1, z);

        // Illegal functions are never acknowledged
        for (int i = 0; i < 20; i++) step("illegal7", 1, 7, 0, 0, 0, z);
        for (int i = 0; i < 3; i++)  step("illegal6", 1, 6, 0, 0, 0, z);

        // Plain mem write, then busrq from IDLE
        step("mw2_idle", 1, 2, 0, 0, 0, mk(1, S_NO, 0, F_NO, 0, 0, 0, 0));
        step("mw2_t1",   0, 2, 0, 0, 0, mk(0, S_T1, 0, F_MW, 0, 0, 0, 0));
        step("mw2_t2",   0, 2, 0, 0, 0, mk(0, S_T2, 0, F_MW, 0, 0, 0, 0));
        step("mw2_t3",   0, 2, 0, 1, 0, mk(0, S_T3, 0, F_MW, 0, 1, 0, 0));
        step("br_t3",    0, 0, 0, 0, 0, mk(0, S_NO, 0, F_NO, 0, 0, 1, 0));
        step("br_idle",  0, 0, 0, 1, 0, z);
        step("br_ack",   0, 0, 0, 0, 0, mk(0, S_NO, 0, F_NO, 0, 0, 1, 0));
        step("br_done",  1, 4, 0, 0, 0, mk(1, S_NO, 0, F_NO, 0, 0, 0, 0));
        step("iw_t1",    0, 4, 0, 0, 0, mk(0, S_T1, 0, F_IW, 0, 0, 0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
